// File: rtl/pll_reset_sequencer_pkg.sv
// pll_reset_sequencer_pkg: state codes and limits shared by the PLL/reset sequencer
package pll_reset_sequencer_pkg;
    localparam logic [2:0] S_RESET_PLL = 3'd0;
    localparam logic [2:0] S_WAIT_LOCK = 3'd1;
    localparam logic [2:0] S_STABLE    = 3'd2;
    localparam logic [2:0] S_RUN       = 3'd3;
    localparam logic [2:0] S_FAIL      = 3'd4;
    localparam logic [7:0] LOCK_LOSS_SAT = 8'd255;
    function automatic int max3(input int a, input int b, input int c);
        return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
    endfunction
endpackage

// File: rtl/pll_lock_synchronizer.sv
// pll_lock_synchronizer: two-flop synchronizer for the asynchronous PLL lock flag
module pll_lock_synchronizer (
    input  logic clk,
    input  logic rstnn,
    input  logic async_in,
    output logic sync_out
);
    logic meta;
    // Capture the lock flag twice so the FSM only sees a settled level
    always_ff @(posedge clk) begin
        if (!rstnn) begin
            meta     <= 1'b0;
            sync_out <= 1'b0;
        end else begin
            meta     <= async_in;
            sync_out <= meta;
        end
    end
endmodule

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: PLL reset / lock / stability sequencing driving the system reset
module pll_reset_sequencer
    import pll_reset_sequencer_pkg::*;
#(
    parameter int PLL_RESET_CYCLES = 16,
    parameter int LOCK_TIMEOUT     = 65536,
    parameter int STABLE_CYCLES    = 1024,
    parameter int MAX_RETRY        = 3
) (
    input  logic       clk,
    input  logic       rstnn,
    input  logic       pll_locked,
    input  logic       sw_reset_req,
    output logic       pll_reset,
    output logic       rstnn_system,
    output logic       seq_fail,
    output logic [2:0] seq_state,
    output logic [3:0] retry_count,
    output logic [7:0] lock_loss_count
);
    localparam int CNT_MAX = max3(PLL_RESET_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
    localparam int CW = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    logic          lock_s;
    logic [2:0]    state, state_nx;
    logic [3:0]    retry_nx;
    logic [CW-1:0] cnt;
    logic          enter;
    logic          lost;

    pll_lock_synchronizer u_sync (
        .clk      (clk),
        .rstnn    (rstnn),
        .async_in (pll_locked),
        .sync_out (lock_s)
    );

    assign seq_state = state;
    assign lost      = (state == S_RUN) && !lock_s;
    assign enter     = (state_nx != state) || sw_reset_req;

    // Next state and retry bookkeeping; a software request overrides everything
    always_comb begin
        state_nx = state;
        retry_nx = retry_count;
        case (state)
            S_RESET_PLL: if (cnt == CW'(PLL_RESET_CYCLES - 1)) state_nx = S_WAIT_LOCK;
            S_WAIT_LOCK: begin
                if (lock_s) begin
                    state_nx = S_STABLE;
                end else if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
                    if (retry_count == 4'(MAX_RETRY)) begin
                        state_nx = S_FAIL;
                    end else begin
                        state_nx = S_RESET_PLL;
                        retry_nx = retry_count + 4'd1;
                    end
                end
            end
            S_STABLE: begin
                if (!lock_s) begin
                    state_nx = S_WAIT_LOCK;
                end else if (cnt == CW'(STABLE_CYCLES - 1)) begin
                    state_nx = S_RUN;
                    retry_nx = '0;
                end
            end
            S_RUN:  if (!lock_s) state_nx = S_RESET_PLL;
            S_FAIL: state_nx = S_FAIL;
            default: state_nx = S_RESET_PLL;
        endcase
        if (sw_reset_req) begin
            state_nx = S_RESET_PLL;
            retry_nx = '0;
        end
    end

    // State, shared counter, loss counter and outputs registered together with the state
    always_ff @(posedge clk) begin
        if (!rstnn) begin
            state           <= S_RESET_PLL;
            cnt             <= '0;
            retry_count     <= '0;
            lock_loss_count <= '0;
            pll_reset       <= 1'b1;
            rstnn_system    <= 1'b0;
            seq_fail        <= 1'b0;
        end else begin
            state        <= state_nx;
            cnt          <= enter ? '0 : cnt + 1'b1;
            retry_count  <= retry_nx;
            pll_reset    <= (state_nx == S_RESET_PLL) || (state_nx == S_FAIL);
            rstnn_system <= (state_nx == S_RUN);
            seq_fail     <= (state_nx == S_FAIL);
            if (lost && lock_loss_count != LOCK_LOSS_SAT)
                lock_loss_count <= lock_loss_count + 8'd1;
        end
    end
endmodule

// File: doc/pll_reset_sequencer.md
# pll_reset_sequencer

Sequences the FPGA clock PLL and the system reset tree. Holds the PLL in reset for a fixed interval, waits for lock with a timeout and bounded retries, then requires a lock-stability window before releasing the system reset. On lock loss or a software request it re-asserts system reset immediately and restarts the sequence. It sits beside the clock PLL wrapper and drives the PLL reset input and the `rstnn_system` net.

## Interface
- `PLL_RESET_CYCLES`, 16: cycles `pll_reset` is held high per attempt (≥1).
- `LOCK_TIMEOUT`, 65536: cycles allowed in WAIT_LOCK per attempt (≥2).
- `STABLE_CYCLES`, 1024: cycles of continuous lock required before release (≥1).
- `MAX_RETRY`, 3: retries after the first attempt before declaring failure (0–15).
- `clk`  in  1: free-running reference clock, independent of PLL output. One clock; all logic on rising edge.
- `rstnn`  in  1: reset, synchronous, active-low.
- `pll_locked`  in  1: PLL lock, asynchronous to `clk`.
- `sw_reset_req`  in  1: single-cycle software restart request, synchronous.
- `pll_reset`  out  1: active-high PLL reset.
- `rstnn_system`  out  1: active-low system reset.
- `seq_fail`  out  1: high while in FAIL.
- `seq_state`  out  3: current state code.
- `retry_count`  out  4: retries used in current sequence.
- `lock_loss_count`  out  8: lock losses seen in RUN, saturating.

## Operation
- `pll_locked` passes through a 2-flop synchronizer; the FSM sees `lock_s` only.
- States and codes: RESET_PLL=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAIL=4. One shared cycle counter `cnt`, cleared on every state entry.
- Outputs are registered and update in the same cycle as the state: `pll_reset`=1 in RESET_PLL and FAIL; `rstnn_system`=1 only in RUN; `seq_fail`=1 only in FAIL.
- RESET_PLL: stays exactly PLL_RESET_CYCLES cycles, then WAIT_LOCK.
- WAIT_LOCK: `lock_s`=1 → STABLE (lock has priority over timeout in the same cycle). Otherwise, at `cnt`=LOCK_TIMEOUT-1: if `retry_count`=MAX_RETRY → FAIL, else increment `retry_count` and go to RESET_PLL.
- STABLE: `lock_s`=0 → WAIT_LOCK with a fresh timeout and no retry charged. At `cnt`=STABLE_CYCLES-1 with `lock_s`=1 → RUN, `retry_count` cleared.
- RUN: `lock_s`=0 → RESET_PLL and `lock_loss_count`+1, saturating at 255.
- FAIL: PLL held in reset; leaves only on `sw_reset_req`.
- `sw_reset_req` in any state → RESET_PLL and `retry_count` cleared. It overrides all other transitions. If a lock loss occurs in RUN in the same cycle, the loss is still counted.
- `lock_loss_count` is cleared only by `rstnn`.

## Timing
- Reset (`rstnn`=0): state RESET_PLL, `cnt`=0, `pll_reset`=1, `rstnn_system`=0, `seq_fail`=0, `seq_state`=0, `retry_count`=0, `lock_loss_count`=0, synchronizer flops 0.
- Cycle 0 is the first cycle after `rstnn` rises.
- Lock input latency: 2 cycles from `pll_locked` to `lock_s`.
- Best case with lock already present: `rstnn_system` rises at cycle PLL_RESET_CYCLES+1+STABLE_CYCLES.
- Lock drop in RUN: `rstnn_system` falls 3 cycles after the `pll_locked` edge (2 synchronizer cycles plus the state register).
- `rstnn` asserted mid-sequence: full reset values apply on the next edge, whatever the state.

## Structure
- Shared package `pll_reset_sequencer_pkg`: state codes (3-bit localparams) and the `lock_loss_count` saturation value.
- `cnt` width is `$clog2` of the maximum of the three cycle parameters.
- Sub-module `pll_lock_synchronizer`: a 2-flop synchronizer with synchronous active-low reset. The FSM, counters and output registers live in the top.

## Test plan
Parameters for all scenarios: PLL_RESET_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRY=2.
- Clean bring-up, `pll_locked`=1 from reset → `pll_reset` high on cycles 0–3; `rstnn_system` rises at cycle 13; `retry_count`=0.
- Never lock → WAIT_LOCK timeouts at cycles 23 and 47; RESET_PLL re-entered at cycles 24 and 48 with `retry_count` 1 then 2; FAIL at cycle 72 with `seq_fail`=1 and `pll_reset`=1; `sw_reset_req` → RESET_PLL next cycle with `retry_count`=0.
- Lock glitch in STABLE: `lock_s` low for 1 cycle after 5 stable cycles → back to WAIT_LOCK with no retry charged; RUN is reached 8 cycles after lock returns.
- Lock loss in RUN, repeated 300 times → `rstnn_system` falls 3 cycles after each `pll_locked` fall; `lock_loss_count` saturates at 255.
- `sw_reset_req` in RUN in the same cycle as `lock_s` falls → RESET_PLL next cycle; `lock_loss_count` increments by exactly 1.
- `rstnn` pulsed low during STABLE → all outputs at reset values on the next edge; the sequence restarts at cycle 0.
